// File: rtl/pfb_rnd_axis_pack.sv
// Output packer behind the PFB rounding stage.
// It delay-aligns valid and phase with the rounded I/Q data and buffers each
// sample in a first-word-fall-through FIFO. The FIFO feeds an AXI-Stream
// master toward the FFT. The pipeline is stalled through the registered `ce`
// before the FIFO can overflow.
module pfb_rnd_axis_pack #(
  parameter int PHASE_WIDTH     = 11,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PIPE_LAT        = 1
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [PHASE_WIDTH-1:0] nfft_m1,
  input  logic                   pfb_valid,
  input  logic [PHASE_WIDTH-1:0] pfb_phase,
  input  logic [15:0]            i_rnd,
  input  logic [15:0]            q_rnd,
  output logic                   ce,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [PHASE_WIDTH-1:0] m_axis_tuser,
  output logic                   phase_err,
  output logic                   overflow
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  // Occupancy ceiling that still leaves room for samples already in the pipe.
  localparam logic [FIFO_ADDR_WIDTH:0] CE_TH = (FIFO_ADDR_WIDTH+1)'(DEPTH - PIPE_LAT - 2);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = (FIFO_ADDR_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic [15:0]            i;
    logic [15:0]            q;
    logic [PHASE_WIDTH-1:0] ph;
    logic                   last;
  } entry_t;

  logic                                ce_r;
  logic [PIPE_LAT-1:0]                 vld_pipe;
  logic [PIPE_LAT-1:0][PHASE_WIDTH-1:0] ph_pipe;
  entry_t                              mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]          wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]            count, count_nxt;
  logic [PHASE_WIDTH-1:0]              exp_ph;

  logic                   dly_vld, wr, rd, wr_acc, full, empty;
  logic [PHASE_WIDTH-1:0] dly_ph, ph_next;
  entry_t                 wr_ent, head;

  assign ce      = ce_r;
  assign dly_vld = vld_pipe[PIPE_LAT-1];
  assign dly_ph  = ph_pipe[PIPE_LAT-1];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr      = ce_r && dly_vld;
  assign rd      = !empty && m_axis_tready;
  // A read in the same cycle frees the slot a write into a full FIFO needs.
  assign wr_acc  = wr && (!full || rd);
  assign ph_next = (dly_ph == nfft_m1) ? '0 : dly_ph + 1'b1;
  assign wr_ent  = '{i: i_rnd, q: q_rnd, ph: dly_ph, last: (dly_ph == nfft_m1)};
  assign head    = mem[rd_ptr];

  // Next occupancy, including this cycle's accepted write and read.
  always_comb begin
    count_nxt = count;
    if (wr_acc) count_nxt = count_nxt + 1'b1;
    if (rd)     count_nxt = count_nxt - 1'b1;
  end

  // Outputs show the head entry. They are zero while the FIFO is empty, so the reset state is clean.
  always_comb begin
    m_axis_tvalid = !empty;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    if (!empty) begin
      m_axis_tdata = {head.i, head.q};
      m_axis_tuser = head.ph;
      m_axis_tlast = head.last;
    end
  end

  // Valid/phase delay line. It advances in lockstep with the ce-stalled rounding pipe.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      vld_pipe <= '0;
      ph_pipe  <= '0;
    end else if (ce_r) begin
      vld_pipe[0] <= pfb_valid;
      ph_pipe[0]  <= pfb_phase;
      for (int k = 1; k < PIPE_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        ph_pipe[k]  <= ph_pipe[k-1];
      end
    end
  end

  // FIFO storage. Contents need no reset because outputs are masked by empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_ent;
  end

  // FIFO pointers, occupancy, and the registered stall enable.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ce_r   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ce_r  <= (count_nxt <= CE_TH);
    end
  end

  // Sticky status: phase-sequence check and dropped-write detection.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      exp_ph    <= '0;
      phase_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr) begin
        if (dly_ph != exp_ph) phase_err <= 1'b1;
        exp_ph <= ph_next;
      end
      if (wr && full && !rd) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pfb_rnd_axis_pack.sv
// Bench for pfb_rnd_axis_pack. It contains a ce-qualified model of the upstream rounding register.
// A sample-sequence scoreboard checks the output, with fixed vector tables for the directed cases.
module tb_pfb_rnd_axis_pack;
  localparam int PW = 11;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b1;
  logic [PW-1:0] nfft_m1 = '0;
  logic          pfb_valid = 1'b0;
  logic [PW-1:0] pfb_phase = '0;
  logic [15:0]   i_rnd = '0, q_rnd = '0;
  logic          ce;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [PW-1:0] m_axis_tuser;
  logic          phase_err, overflow;

  pfb_rnd_axis_pack #(.PHASE_WIDTH(PW), .FIFO_ADDR_WIDTH(4), .PIPE_LAT(1)) dut (
    .clk(clk), .sync_reset(sync_reset), .nfft_m1(nfft_m1),
    .pfb_valid(pfb_valid), .pfb_phase(pfb_phase), .i_rnd(i_rnd), .q_rnd(q_rnd),
    .ce(ce), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .phase_err(phase_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] ph; logic [15:0] i; logic [15:0] q; } smp_t;
  typedef struct { logic [31:0] data; logic [PW-1:0] user; logic last; logic err; } beat_t;
  typedef struct { logic [PW-1:0] ph; logic [31:0] data; logic last; logic err; } vec_t;

  smp_t  src[$];
  beat_t exp_q[$];
  beat_t cap[$];
  smp_t  cur;
  int    errors = 0, checks = 0;
  int    rdy_pct = 100, vld_pct = 100, ce_zero = 0;
  logic [PW-1:0] m_exp_ph;
  logic          m_err;
  bit            prev_stall = 0;
  beat_t         prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // The expected output is simply the accepted input sequence. The phase-error
  // value at each point follows the "expected next phase" rule.
  task automatic model_push(input smp_t s);
    beat_t e;
    e.data = {s.i, s.q};
    e.user = s.ph;
    e.last = (s.ph == nfft_m1);
    if (s.ph != m_exp_ph) m_err = 1'b1;
    m_exp_ph = (s.ph == nfft_m1) ? '0 : s.ph + 1'b1;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    bit ce_s;
    beat_t e, b;
    @(negedge clk);
    ce_s = ce;
    if (!ce) ce_zero++;
    if (prev_stall) begin
      chk("hold_tvalid", m_axis_tvalid, 1'b1);
      chk("hold_tdata", m_axis_tdata, prev.data);
      chk("hold_tuser", m_axis_tuser, prev.user);
      chk("hold_tlast", m_axis_tlast, prev.last);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      b = '{m_axis_tdata, m_axis_tuser, m_axis_tlast, phase_err};
      cap.push_back(b);
      if (exp_q.size() == 0) chk("spurious_beat", m_axis_tvalid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("sb_tdata", m_axis_tdata, e.data);
        chk("sb_tuser", m_axis_tuser, e.user);
        chk("sb_tlast", m_axis_tlast, e.last);
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev = '{m_axis_tdata, m_axis_tuser, m_axis_tlast, 1'b0};
    @(posedge clk);
    #1;
    // Upstream rounding register: loads only on ce edges, one ce-cycle after pfb_valid.
    if (ce_s && pfb_valid) begin
      i_rnd = cur.i;
      q_rnd = cur.q;
      model_push(cur);
      void'(src.pop_front());
      pfb_valid = 1'b0;
    end
    if (ce_s || !pfb_valid) begin
      pfb_valid = (src.size() > 0) && (int'($urandom_range(99)) < vld_pct);
      if (pfb_valid) begin
        cur = src[0];
        pfb_phase = cur.ph;
      end
    end
    m_axis_tready = int'($urandom_range(99)) < rdy_pct;
  endtask

  task automatic do_reset(input logic [PW-1:0] n);
    sync_reset = 1'b1;
    nfft_m1 = n;
    pfb_valid = 1'b0;
    src.delete(); exp_q.delete(); cap.delete();
    m_exp_ph = '0; m_err = 1'b0; prev_stall = 0;
    repeat (2) @(posedge clk);
    #1 sync_reset = 1'b0;
    @(negedge clk);
    chk("rst_ce", ce, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tuser", m_axis_tuser, '0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_phase_err", phase_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((src.size() > 0 || exp_q.size() > 0 || pfb_valid) && n < limit) begin
      cyc();
      n++;
    end
    chk("drain_timeout_left", exp_q.size(), 0);
  endtask

  task automatic add(input int ph, input logic [15:0] i, input logic [15:0] q);
    smp_t s;
    s.ph = PW'(ph); s.i = i; s.q = q;
    src.push_back(s);
  endtask

  vec_t tbl1[24];
  vec_t tblg[9];
  int   gph[9] = '{0, 1, 2, 5, 6, 7, 0, 1, 2};
  bit   gerr[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    logic [15:0] p16;
    int consumed;
    for (int k = 0; k < 24; k++) begin
      p16 = 16'(k % 8);
      tbl1[k] = '{PW'(k % 8), {p16, 16'd0 - p16}, (k % 8) == 7, 1'b0};
    end
    for (int k = 0; k < 9; k++) begin
      p16 = 16'(gph[k]);
      tblg[k] = '{PW'(gph[k]), {p16, 16'd0 - p16}, gph[k] == 7, gerr[k]};
    end

    // Streaming frames with tready held high.
    do_reset(7);
    rdy_pct = 100; vld_pct = 100;
    for (int k = 0; k < 24; k++) add(k % 8, 16'(k % 8), 16'd0 - 16'(k % 8));
    cyc();
    ce_zero = 0;
    drain(200);
    chk("t1_beats", cap.size(), 24);
    for (int k = 0; k < 24 && k < cap.size(); k++) begin
      chk("t1_tdata", cap[k].data, tbl1[k].data);
      chk("t1_tuser", cap[k].user, tbl1[k].ph);
      chk("t1_tlast", cap[k].last, tbl1[k].last);
    end
    chk("t1_ce_held", ce_zero, 0);
    chk("t1_phase_err", phase_err, 1'b0);
    chk("t1_overflow", overflow, 1'b0);

    // Full backpressure: ce must throttle before the FIFO overflows.
    do_reset(7);
    rdy_pct = 0;
    for (int k = 0; k < 30; k++) add(k % 8, 16'(k % 8), 16'd0 - 16'(k % 8));
    repeat (25) cyc();
    consumed = 30 - src.size();
    chk("bp_ce_low", ce, 1'b0);
    chk("bp_tvalid", m_axis_tvalid, 1'b1);
    chk("bp_no_overflow", overflow, 1'b0);
    chk("bp_consumed_le_depth", consumed <= 16, 1'b1);
    rdy_pct = 100;
    drain(300);
    chk("bp_ce_back", ce, 1'b1);
    chk("bp_no_overflow_end", overflow, 1'b0);
    chk("bp_phase_err", phase_err, 1'b0);

    // Random ready and valid gaps, 64-phase frames.
    do_reset(63);
    rdy_pct = 50; vld_pct = 80;
    for (int k = 0; k < 1000; k++) add(k % 64, 16'($urandom), 16'($urandom));
    drain(6000);
    chk("rnd_beats", cap.size(), 1000);
    chk("rnd_overflow", overflow, 1'b0);
    chk("rnd_phase_err", phase_err, 1'b0);
    rdy_pct = 100; vld_pct = 100;

    // Phase glitch: error sets at the beat with tuser=5 and stays set.
    do_reset(7);
    for (int k = 0; k < 9; k++) add(gph[k], 16'(gph[k]), 16'd0 - 16'(gph[k]));
    drain(100);
    chk("g_beats", cap.size(), 9);
    for (int k = 0; k < 9 && k < cap.size(); k++) begin
      chk("g_tuser", cap[k].user, tblg[k].ph);
      chk("g_tdata", cap[k].data, tblg[k].data);
      chk("g_tlast", cap[k].last, tblg[k].last);
      chk("g_phase_err", cap[k].err, tblg[k].err);
    end

    // Mid-stream reset with the FIFO partly full and phase_err set.
    do_reset(7);
    rdy_pct = 0;
    for (int k = 0; k < 12; k++) add(k == 0 ? 0 : k + 1, 16'(k), 16'(k));
    repeat (12) cyc();
    chk("mr_buffered", dut.count >= 5'd10, 1'b1);
    chk("mr_err_before", phase_err, 1'b1);
    do_reset(7);
    rdy_pct = 100;
    for (int k = 0; k < 8; k++) add(k, 16'(k), 16'd0 - 16'(k));
    drain(100);
    chk("mr_beats", cap.size(), 8);
    for (int k = 0; k < 8 && k < cap.size(); k++) begin
      chk("mr_tdata", cap[k].data, tbl1[k].data);
      chk("mr_tlast", cap[k].last, tbl1[k].last);
    end
    chk("mr_phase_err", phase_err, 1'b0);

    // Forced ce with no reads: the 17th write is dropped.
    do_reset(7);
    rdy_pct = 0;
    force dut.ce_r = 1'b1;
    for (int k = 0; k < 20; k++) add(k % 8, 16'(100 + k), 16'(k));
    repeat (24) cyc();
    chk("ov_consumed", src.size(), 0);
    chk("ov_overflow", overflow, 1'b1);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    release dut.ce_r;
    rdy_pct = 100;
    drain(100);
    chk("ov_beats", cap.size(), 16);
    chk("ov_sticky", overflow, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
